// File: rtl/moving_rank_filter.sv
// rtl/moving_rank_filter.sv - sliding-window rank-order filter with insertion-sorted window
module moving_rank_filter #(
   parameter int WIDTH           = 16,
   parameter int DEPTH           = 5,
   parameter int GATE_UNTIL_FULL = 0
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    InValid,
   input  logic signed [WIDTH-1:0] Input,
   input  logic [4:0]              Rank,
   input  logic                    Flush,
   output logic signed [WIDTH-1:0] Output,
   output logic                    OutValid,
   output logic                    Filled
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [PW-1:0] RANK_MAX = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   generate
      if ((DEPTH % 2) == 0 || DEPTH < 3 || DEPTH > 31) begin : g_bad_depth
         $error("moving_rank_filter: DEPTH must be odd and within 3..31");
      end
   endgenerate

   logic signed [WIDTH-1:0] hist        [DEPTH];
   logic signed [WIDTH-1:0] sorted      [DEPTH];
   logic signed [WIDTH-1:0] sorted_next [DEPTH];
   logic signed [WIDTH-1:0] rem         [DEPTH-1];
   logic [PW-1:0]           ptr;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           cnt_next;
   logic [PW-1:0]           rank_reg;
   logic [PW-1:0]           rank_clamped;
   logic                    pend;
   logic                    accept;
   logic                    emit_next;
   logic signed [WIDTH-1:0] oldest;
   int                      rm_idx;
   int                      ins_pos;

   assign accept       = InValid && !Flush;
   assign oldest       = hist[ptr];
   assign cnt_next     = (cnt == CNT_FULL) ? cnt : cnt + 1'b1;
   assign rank_clamped = (Rank >= 5'(DEPTH)) ? RANK_MAX : Rank[PW-1:0];
   assign emit_next    = accept && ((GATE_UNTIL_FULL == 0) || (cnt_next == CNT_FULL));
   assign Filled       = (cnt == CNT_FULL);

   // Drop one copy of the departing sample, then slot the new one in ascending order
   always_comb begin
      rm_idx  = DEPTH - 1;
      ins_pos = 0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (sorted[i] == oldest) begin
            rm_idx = i;
         end
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         rem[i] = (i < rm_idx) ? sorted[i] : sorted[i+1];
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (rem[i] < Input) begin
            ins_pos = ins_pos + 1;
         end
      end
      sorted_next[0] = (ins_pos == 0) ? Input : rem[0];
      for (int i = 1; i < DEPTH - 1; i++) begin
         if (i < ins_pos) begin
            sorted_next[i] = rem[i];
         end else if (i == ins_pos) begin
            sorted_next[i] = Input;
         end else begin
            sorted_next[i] = rem[i-1];
         end
      end
      sorted_next[DEPTH-1] = (ins_pos == DEPTH - 1) ? Input : rem[DEPTH-2];
   end

   // Window state: history ring, sorted copy, fill count and the rank for the pending result
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            hist[i]   <= '0;
            sorted[i] <= '0;
         end
         ptr      <= '0;
         cnt      <= '0;
         rank_reg <= '0;
      end else if (Flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            hist[i]   <= '0;
            sorted[i] <= '0;
         end
         ptr <= '0;
         cnt <= '0;
      end else if (InValid) begin
         hist[ptr] <= Input;
         ptr       <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            sorted[i] <= sorted_next[i];
         end
         cnt      <= cnt_next;
         rank_reg <= rank_clamped;
      end
   end

   // Result stage: one edge after the accept, pick the selected rank from the updated window
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pend     <= 1'b0;
         Output   <= '0;
         OutValid <= 1'b0;
      end else begin
         pend     <= emit_next;
         OutValid <= pend;
         if (pend) begin
            Output <= sorted[rank_reg];
         end
      end
   end

endmodule

// File: tb/tb_moving_rank_filter.sv
// tb/tb_moving_rank_filter.sv - self-checking bench for moving_rank_filter
module tb_moving_rank_filter;

   logic               clk;
   logic               rst_n;
   logic               inv;
   logic signed [15:0] din;
   logic [4:0]         rank;
   logic               flush;
   logic signed [15:0] outs [3];
   logic               ovs  [3];
   logic               fls  [3];

   int n_cmp = 0;
   int n_bad = 0;

   // three configurations share one stimulus stream
   int dep [3] = '{5, 3, 3};
   int gat [3] = '{0, 0, 1};

   // reference model: window kept oldest-first, result picked by counting
   int win      [3][31];
   int cnt      [3];
   int pend_v   [3];
   int pend_val [3];
   int exp_out  [3];
   int exp_val  [3];

   typedef struct {
      bit inv;
      int din;
      int rank;
      bit flush;
      bit ev;
      int eo;
      bit ef;
   } vec_t;

   vec_t tbl [7];

   moving_rank_filter #(.WIDTH(16), .DEPTH(5), .GATE_UNTIL_FULL(0)) u_d5 (
      .Clk(clk), .Reset(rst_n), .InValid(inv), .Input(din), .Rank(rank), .Flush(flush),
      .Output(outs[0]), .OutValid(ovs[0]), .Filled(fls[0]));

   moving_rank_filter #(.WIDTH(16), .DEPTH(3), .GATE_UNTIL_FULL(0)) u_d3 (
      .Clk(clk), .Reset(rst_n), .InValid(inv), .Input(din), .Rank(rank), .Flush(flush),
      .Output(outs[1]), .OutValid(ovs[1]), .Filled(fls[1]));

   moving_rank_filter #(.WIDTH(16), .DEPTH(3), .GATE_UNTIL_FULL(1)) u_d3g (
      .Clk(clk), .Reset(rst_n), .InValid(inv), .Input(din), .Rank(rank), .Flush(flush),
      .Output(outs[2]), .OutValid(ovs[2]), .Filled(fls[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input int m, input int r);
      int rc;
      int lt;
      int le;
      int res;
      rc  = (r >= dep[m]) ? dep[m] - 1 : r;
      res = 0;
      for (int i = 0; i < dep[m]; i++) begin
         lt = 0;
         le = 0;
         for (int j = 0; j < dep[m]; j++) begin
            if (win[m][j] < win[m][i])  lt++;
            if (win[m][j] <= win[m][i]) le++;
         end
         if (lt <= rc && rc < le) res = win[m][i];
      end
      return res;
   endfunction

   task automatic model_clear_window(input int m);
      for (int i = 0; i < 31; i++) win[m][i] = 0;
      cnt[m] = 0;
   endtask

   task automatic model_reset();
      for (int m = 0; m < 3; m++) begin
         model_clear_window(m);
         pend_v[m]   = 0;
         pend_val[m] = 0;
         exp_out[m]  = 0;
         exp_val[m]  = 0;
      end
   endtask

   task automatic model_edge(input bit v, input int x, input int r, input bit f);
      for (int m = 0; m < 3; m++) begin
         exp_val[m] = pend_v[m];
         if (pend_v[m] != 0) exp_out[m] = pend_val[m];
         if (f) begin
            model_clear_window(m);
            pend_v[m] = 0;
         end else if (v) begin
            for (int i = 0; i < dep[m] - 1; i++) win[m][i] = win[m][i+1];
            win[m][dep[m]-1] = x;
            if (cnt[m] < dep[m]) cnt[m]++;
            pend_val[m] = pick(m, r);
            pend_v[m]   = (gat[m] == 0 || cnt[m] == dep[m]) ? 1 : 0;
         end else begin
            pend_v[m] = 0;
         end
      end
   endtask

   task automatic check_all();
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("out[%0d]", m), int'(outs[m]), exp_out[m]);
         chk($sformatf("valid[%0d]", m), int'(ovs[m]), exp_val[m]);
         chk($sformatf("filled[%0d]", m), int'(fls[m]), (cnt[m] == dep[m]) ? 1 : 0);
      end
   endtask

   task automatic step(input bit v, input int x, input int r, input bit f);
      inv   = v;
      din   = 16'(x);
      rank  = 5'(r);
      flush = f;
      @(posedge clk);
      #1;
      model_edge(v, x, r, f);
      check_all();
   endtask

   initial begin
      logic [15:0] rv;
      int          x;
      int          impulse_bad;

      tbl[0] = '{1'b1,   10, 2, 1'b0, 1'b0, 0, 1'b0};
      tbl[1] = '{1'b1,   -3, 2, 1'b0, 1'b1, 0, 1'b0};
      tbl[2] = '{1'b1,    7, 2, 1'b0, 1'b1, 0, 1'b0};
      tbl[3] = '{1'b1,  100, 2, 1'b0, 1'b1, 0, 1'b0};
      tbl[4] = '{1'b1,    4, 2, 1'b0, 1'b1, 7, 1'b1};
      tbl[5] = '{1'b0,    0, 2, 1'b0, 1'b1, 7, 1'b1};
      tbl[6] = '{1'b0,    0, 2, 1'b0, 1'b0, 7, 1'b1};

      rst_n = 1'b0;
      inv   = 1'b0;
      din   = '0;
      rank  = '0;
      flush = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // basic window fill against fixed expectations for the 5-deep instance
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].inv, tbl[i].din, tbl[i].rank, tbl[i].flush);
         chk($sformatf("tbl_out[%0d]", i), int'(outs[0]), tbl[i].eo);
         chk($sformatf("tbl_valid[%0d]", i), int'(ovs[0]), int'(tbl[i].ev));
         chk($sformatf("tbl_filled[%0d]", i), int'(fls[0]), int'(tbl[i].ef));
      end

      // impulse rejection: once full of 50s, a lone spike never reaches the median
      step(1'b0, 0, 2, 1'b1);
      impulse_bad = 0;
      for (int i = 0; i < 14; i++) begin
         step(1'b1, (i == 7) ? 30000 : 50, 2, 1'b0);
         if (i >= 5 && (ovs[0] != 1'b1 || outs[0] != 16'sd50)) impulse_bad++;
      end
      chk("impulse_rejection", impulse_bad, 0);

      // rank sweep on extremes; refeeding the oldest value keeps the multiset intact
      step(1'b0, 0, 2, 1'b1);
      step(1'b1, -32768, 2, 1'b0);
      step(1'b1, -1, 2, 1'b0);
      step(1'b1, 0, 2, 1'b0);
      step(1'b1, 1, 2, 1'b0);
      step(1'b1, 32767, 2, 1'b0);
      step(1'b1, -32768, 0, 1'b0);
      step(1'b1, -1, 4, 1'b0);
      chk("rank0_min", int'(outs[0]), -32768);
      step(1'b1, 0, 9, 1'b0);
      chk("rank4_max", int'(outs[0]), 32767);
      step(1'b0, 0, 0, 1'b0);
      chk("rank9_clamp", int'(outs[0]), 32767);

      // ties under continuous valid
      step(1'b0, 0, 2, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, (i < 3) ? 5 : 2, 2, 1'b0);
      chk("ties_last_valid", int'(ovs[0]), 1);
      step(1'b0, 0, 2, 1'b0);
      chk("ties_last_out", int'(outs[0]), 2);

      // gated instance: flush then two accepts never pulse
      step(1'b0, 0, 1, 1'b1);
      step(1'b1, 3, 1, 1'b0);
      step(1'b1, 4, 1, 1'b0);
      step(1'b0, 0, 1, 1'b0);
      chk("gate_no_pulse", int'(ovs[2]), 0);
      chk("gate_not_filled", int'(fls[2]), 0);

      // asynchronous reset between edges, then restart with 9,9,9
      for (int i = 0; i < 4; i++) step(1'b1, 20 + i, 1, 1'b0);
      inv = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("async_out[%0d]", m), int'(outs[m]), 0);
         chk($sformatf("async_valid[%0d]", m), int'(ovs[m]), 0);
         chk($sformatf("async_filled[%0d]", m), int'(fls[m]), 0);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 9, 1, 1'b0);
      step(1'b1, 9, 1, 1'b0);
      chk("restart_r1", int'(outs[1]), 0);
      step(1'b1, 9, 1, 1'b0);
      chk("restart_r2", int'(outs[1]), 9);
      step(1'b0, 0, 1, 1'b0);
      chk("restart_r3", int'(outs[1]), 9);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rv = 16'($urandom);
         case ($urandom_range(0, 9))
            0:       x = -32768;
            1:       x = 32767;
            2:       x = int'($urandom_range(0, 3)) - 1;
            default: x = int'($signed(rv));
         endcase
         step(($urandom_range(0, 3) != 0), x, int'($urandom_range(0, 31)),
              ($urandom_range(0, 39) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
